// File: rtl/conv_mac_engine.sv
// Sequential MAC convolution over a 2x2/3x3/5x5 window with shift-normalise, clamp and valid/ready output.
// Optional build macro: CONV_ABS_EN (fold negative sums to their magnitude before clamping).
module conv_mac_engine #(
  parameter int ACC_W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [199:0] matrix,
  input  logic [199:0] kernel,
  input  logic [1:0]   size,
  input  logic [3:0]   shift,
  output logic         next_matrix,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   pixel_out,
  output logic         sat
);

  typedef enum logic [1:0] {IDLE, MAC, NORM, OUT} state_t;

  state_t                    state_reg;
  logic [199:0]              mat_reg;
  logic [199:0]              ker_reg;
  logic [2:0]                last_reg;
  logic [3:0]                shift_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [2:0]                row_reg;
  logic [2:0]                col_reg;
  logic                      illegal_reg;

  logic [7:0]                pix_arr  [25];
  logic signed [7:0]         coef_arr [25];
  logic [4:0]                idx;
  logic signed [16:0]        prod;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   s_val;
  logic signed [ACC_W-1:0]   mag;
  logic [7:0]                norm_pix;
  logic                      norm_sat;

  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_unpack
      assign pix_arr[gi]  = mat_reg[8*gi +: 8];
      assign coef_arr[gi] = ker_reg[8*gi +: 8];
    end
  endgenerate

  assign idx      = 5'(row_reg) * 5'd5 + 5'(col_reg);
  assign prod     = $signed({1'b0, pix_arr[idx]}) * coef_arr[idx];
  assign acc_next = acc_reg + {{(ACC_W-17){prod[16]}}, prod};
  assign s_val    = acc_reg >>> shift_reg;

  always_comb begin
    norm_pix = '0;
    norm_sat = 1'b0;
`ifdef CONV_ABS_EN
    mag = (s_val < 0) ? -s_val : s_val;
    if (mag > 255) begin
      norm_pix = 8'd255;
      norm_sat = 1'b1;
    end else begin
      norm_pix = mag[7:0];
    end
`else
    mag = s_val;
    if (s_val < 0) begin
      norm_sat = 1'b1;
    end else if (s_val > 255) begin
      norm_pix = 8'd255;
      norm_sat = 1'b1;
    end else begin
      norm_pix = s_val[7:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mat_reg     <= '0;
      ker_reg     <= '0;
      last_reg    <= '0;
      shift_reg   <= '0;
      acc_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      illegal_reg <= 1'b0;
      next_matrix <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      pixel_out   <= '0;
      sat         <= 1'b0;
    end else begin
      next_matrix <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mat_reg     <= matrix;
            ker_reg     <= kernel;
            shift_reg   <= shift;
            acc_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            next_matrix <= 1'b1;
            busy        <= 1'b1;
            last_reg    <= (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
            // Illegal size spends one extra NORM cycle so its latency stays at 3
            illegal_reg <= (size == 2'd2);
            state_reg   <= (size == 2'd2) ? NORM : MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          if (col_reg == last_reg) begin
            col_reg <= '0;
            if (row_reg == last_reg) state_reg <= NORM;
            else                     row_reg   <= row_reg + 3'd1;
          end else begin
            col_reg <= col_reg + 3'd1;
          end
        end
        NORM: begin
          if (illegal_reg) begin
            illegal_reg <= 1'b0;
          end else begin
            pixel_out <= norm_pix;
            sat       <= norm_sat;
            out_valid <= 1'b1;
            state_reg <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine (honours CONV_ABS_EN for the negative-sum case).
module tb_conv_mac_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] matrix;
  logic [199:0] kernel;
  logic [1:0]   size;
  logic [3:0]   shift;
  logic         next_matrix;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pixel_out;
  logic         sat;

  int errors = 0;
  int checks = 0;

  conv_mac_engine #(.ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix(matrix), .kernel(kernel),
    .size(size), .shift(shift), .next_matrix(next_matrix), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] p, input logic [7:0] c, input int n);
    for (int k = 0; k < 25; k++) begin
      matrix[8*k +: 8] = p;
      kernel[8*k +: 8] = ((k / 5) < n && (k % 5) < n) ? c : 8'd0;
    end
  endtask

  // Start a run and wait for out_valid; checks latency and the single next_matrix pulse.
  task automatic launch(input logic [1:0] sz, input logic [3:0] sh, input int exp_lat, input string tag);
    int cyc;
    int nm_extra;
    size  = sz;
    shift = sh;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    matrix = ~matrix;
    kernel = ~kernel;
    size   = 2'd1;
    shift  = 4'd0;
    cyc = 1;
    nm_extra = 0;
    check({tag, "_nm_c1"}, next_matrix, 1);
    check({tag, "_busy_c1"}, busy, 1);
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (next_matrix) nm_extra++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_nm_extra"}, nm_extra, 0);
    $display("txn %s: latency=%0d pixel_out=%0d sat=%0d", tag, cyc, pixel_out, sat);
  endtask

  initial begin
    int bad;
    logic [7:0] held;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    matrix = '0; kernel = '0; size = 2'd0; shift = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_next_matrix", next_matrix, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_sat", sat, 0);

    // 3x3 box filter: 9 * 10 * 1 = 90; inputs scrambled after capture
    fill(8'd10, 8'd1, 3);
    launch(2'd1, 4'd0, 11, "box3");
    check("box3_pixel", pixel_out, 90);
    check("box3_sat", sat, 0);
    @(posedge clk); #1;
    check("box3_valid_drop", out_valid, 0);
    check("box3_busy_drop", busy, 0);

    // 5x5 saturation: 25*255*127 = 809625, >>4 = 50601 -> 255
    fill(8'd255, 8'd127, 5);
    launch(2'd3, 4'd4, 27, "sat5");
    check("sat5_pixel", pixel_out, 255);
    check("sat5_sat", sat, 1);
    @(posedge clk); #1;

    // 2x2 negative sum: 200 * -1
    matrix = '0; kernel = '0;
    matrix[7:0] = 8'd200;
    kernel[7:0] = 8'hFF;
    launch(2'd0, 4'd0, 6, "neg2");
`ifdef CONV_ABS_EN
    check("neg2_pixel", pixel_out, 200);
    check("neg2_sat", sat, 0);
`else
    check("neg2_pixel", pixel_out, 0);
    check("neg2_sat", sat, 1);
`endif
    @(posedge clk); #1;

    // Backpressure, mixed signs, padding full of large values that must not be read:
    // 100*2 + 50*(-1) + 20*3 + 10*1 = 220, >>1 = 110
    fill(8'd255, 8'd127, 5);
    matrix[8*0 +: 8] = 8'd100; kernel[8*0 +: 8] = 8'd2;
    matrix[8*1 +: 8] = 8'd50;  kernel[8*1 +: 8] = 8'hFF;
    matrix[8*5 +: 8] = 8'd20;  kernel[8*5 +: 8] = 8'd3;
    matrix[8*6 +: 8] = 8'd10;  kernel[8*6 +: 8] = 8'd1;
    out_ready = 1'b0;
    launch(2'd0, 4'd1, 6, "bp2");
    check("bp2_pixel", pixel_out, 110);
    check("bp2_sat", sat, 0);
    held = pixel_out;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(posedge clk); #1;
      if (pixel_out !== held || !out_valid || !busy || next_matrix) bad++;
    end
    start = 1'b0;
    check("bp2_hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp2_valid_drop", out_valid, 0);
    check("bp2_busy_drop", busy, 0);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || out_valid) bad++;
    end
    check("bp2_start_ignored", bad, 0);

    // Reset in MAC cycle 4 of a 5x5 run
    fill(8'd10, 8'd1, 5);
    size = 2'd3; shift = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_pixel", pixel_out, 0);
    check("midrst_sat", sat, 0);
    check("midrst_nm", next_matrix, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("midrst_no_output", bad, 0);
    $display("txn midrst: post-release activity cycles=%0d", bad);

    // Illegal size: latency 3, result 0 without saturation
    fill(8'd200, 8'd100, 5);
    launch(2'd2, 4'd0, 3, "ill");
    check("ill_pixel", pixel_out, 0);
    check("ill_sat", sat, 0);
    @(posedge clk); #1;
    check("ill_valid_drop", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
